// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the direct-mapped read cache
package icache_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int OFFSET_W   = 2;
  localparam int LINE_BYTES = 4;
  localparam logic [1:0] BURST_LEN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_REFILL,
    ST_RESP
  } state_t;

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data flop arrays with flush-all, byte and tag write ports
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_all,
  input  logic                         byte_we,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [OFFSET_W-1:0]          byte_sel,
  input  logic [DATA_W-1:0]            byte_data,
  input  logic                         tag_we,
  input  logic                         tag_valid,
  input  logic [TAG_W-1:0]             tag_data,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_BYTES*DATA_W-1:0] rd_line
);

  logic [LINES-1:0]            valid_q;
  logic [TAG_W-1:0]            tag_q  [LINES];
  logic [LINE_BYTES*DATA_W-1:0] data_q [LINES];

  // Valid bits: cleared by reset or flush, otherwise updated through the tag port.
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= tag_valid;
    end
  end

  // Tags need no reset; they are only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[wr_idx] <= tag_data;
    end
  end

  // One refill beat lands in one byte lane of the line.
  always_ff @(posedge clk) begin
    if (byte_we) begin
      data_q[wr_idx][{byte_sel, 3'b000} +: DATA_W] <= byte_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_rd_direct.sv
// rtl/icache_rd_direct.sv - direct-mapped read-only byte cache; ICACHE_PERF_EN adds hit/miss counters
module icache_rd_direct
  import icache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_flush,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_rreq,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [1:0]        mem_burst_len,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_rlast
`ifdef ICACHE_PERF_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 8 - IDX_W;

  state_t                       state_q, state_d;
  logic                         ready_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [OFFSET_W-1:0]          cnt_q;
  logic [OFFSET_W-1:0]          off;
  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic                         rd_valid;
  logic [TAG_W-1:0]             rd_tag;
  logic [LINE_BYTES*DATA_W-1:0] rd_line;
  logic                         hit;
  logic                         flush_all;
  logic                         byte_we;
  logic                         tag_we;
  logic                         tag_valid;

  assign off  = addr_q[OFFSET_W-1:0];
  assign idx  = addr_q[OFFSET_W +: IDX_W];
  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign hit  = rd_valid && (rd_tag == tag);
  assign mem_burst_len = BURST_LEN;

  icache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .flush_all (flush_all),
    .byte_we   (byte_we),
    .wr_idx    (idx),
    .byte_sel  (cnt_q),
    .byte_data (mem_rdata),
    .tag_we    (tag_we),
    .tag_valid (tag_valid),
    .tag_data  (tag),
    .rd_idx    (idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  // State register; ready_q keeps cpu_ready low for the whole reset and the cycle leaving it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  // Latch the accepted address and count refill beats (restarted from the request cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_LOOKUP) begin
        addr_q <= cpu_addr;
      end
      if (state_q == ST_MISS_REQ) begin
        cnt_q <= '0;
      end else if (state_q == ST_REFILL && mem_rvalid) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Next state, port outputs and store write controls, all decoded from registered state.
  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    mem_rreq   = 1'b0;
    mem_raddr  = '0;
    flush_all  = 1'b0;
    byte_we    = 1'b0;
    tag_we     = 1'b0;
    tag_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_ready = ready_q && !cpu_flush;
        if (cpu_flush) begin
          flush_all = 1'b1;
        end else if (cpu_req && ready_q) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = rd_line[{off, 3'b000} +: DATA_W];
          state_d    = ST_IDLE;
        end else begin
          tag_we  = 1'b1;
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_rreq  = 1'b1;
        mem_raddr = {addr_q[ADDR_W-1:OFFSET_W], 2'b00};
        state_d   = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_rvalid) begin
          byte_we = 1'b1;
          if (mem_rlast) begin
            tag_we    = 1'b1;
            tag_valid = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = rd_line[{off, 3'b000} +: DATA_W];
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ICACHE_PERF_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating lookup outcome counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (hit && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (!hit && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

`ifndef SYNTHESIS
  // A burst must end on its fourth beat; the line is still marked valid if it does not.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_REFILL && mem_rvalid && mem_rlast) begin
      assert (cnt_q == 2'd3);
    end
  end
`endif

endmodule

// File: doc/icache_rd_direct.md
# icache_rd_direct

Direct-mapped, read-only byte cache between the CPU load port and the latency RAM stage. Hits return in one cycle. Misses issue one 4-beat burst read to the RAM stage, fill the line from the byte stream (`mem_rvalid`/`mem_rlast`), then return the requested byte.

## Interface
- `LINES`, 16: number of cache lines; power of two, 2..64. `IDX_W = log2(LINES)`, `TAG_W = 8 - IDX_W`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cpu_req`  in  1  read request; sampled only when `cpu_ready`=1.
- `cpu_addr`  in  10  byte address; fields are {tag, index, offset[1:0]}.
- `cpu_flush`  in  1  invalidate all lines; sampled only in IDLE.
- `cpu_ready`  out  1  request accepted this cycle if `cpu_req`=1.
- `cpu_rvalid`  out  1  one-cycle pulse; `cpu_rdata` is valid.
- `cpu_rdata`  out  8  returned byte; 0 when `cpu_rvalid`=0.
- `mem_rreq`  out  1  burst read request; one-cycle pulse.
- `mem_raddr`  out  10  line base address {tag, index, 2'b00}; valid while `mem_rreq`=1, 0 otherwise.
- `mem_burst_len`  out  2  constant 2'd3 (4 beats).
- `mem_rdata`  in  8  beat data.
- `mem_rvalid`  in  1  beat valid.
- `mem_rlast`  in  1  final beat.
- `hit_cnt`, `miss_cnt`  out  16 each  present only with `ICACHE_PERF_EN`.

## Operation
- Storage per line: `valid`, tag[`TAG_W`], 4 bytes. All storage is flops.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE
  - `cpu_ready` = !`cpu_flush`.
  - If `cpu_flush`=1: clear all valid bits; stay in IDLE. Flush has priority over `cpu_req` in the same cycle; the request is not accepted.
  - Else if `cpu_req`=1: latch `cpu_addr`, go to LOOKUP.
- LOOKUP
  - Hit (`valid[idx]` and tag match): `cpu_rvalid`=1, `cpu_rdata` = `line[idx][off]`, go to IDLE.
  - Miss: invalidate `line[idx]`, go to MISS_REQ.
- MISS_REQ: `mem_rreq`=1 with `mem_raddr` = line base for exactly one cycle, then go to REFILL.
- REFILL
  - Beat counter is 2 bits, reset to 0 on entry.
  - Each `mem_rvalid` writes `mem_rdata` into `line[idx][cnt]` and increments `cnt`. Beat k holds the byte at base+k.
  - On `mem_rvalid` && `mem_rlast`: set valid, write tag, go to RESP.
  - If `mem_rlast` arrives with `cnt`≠3, the line is still marked valid; this is a protocol error and is asserted in simulation only.
- RESP: `cpu_rvalid`=1, `cpu_rdata` = filled byte at the latched offset; go to IDLE.
- `mem_rvalid` outside REFILL is ignored.
- `cpu_req` and `cpu_flush` outside IDLE are ignored; the CPU must hold its request until `cpu_ready`.
- Reset at any point (including mid-refill): state IDLE, all valid bits 0, counters 0, all outputs 0 except `mem_burst_len`=3. The RAM stage shares the same reset, so no stale beats arrive afterwards.

## Timing
- Hit: `cpu_rvalid` 1 cycle after the accept cycle.
- Miss: accept at cycle 0, LOOKUP at 1, `mem_rreq` at 2. With a RAM stage of 11 WAIT cycles, beats arrive at cycles 14-17 and `cpu_rvalid` is at cycle 18.
- Back-to-back: `cpu_ready` is high again in the cycle after `cpu_rvalid`. Maximum hit throughput is one request per 2 cycles.
- All outputs are combinational decodes of the registered state and storage; there is no input-to-output combinational path except `cpu_flush`→`cpu_ready`.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_cnt` increments on each LOOKUP hit.
  - `miss_cnt` increments on each LOOKUP miss.
  - Both saturate at 16'hFFFF and are cleared by reset only; flush does not clear them.
- Not defined: the ports, registers and logic are absent.

## Structure
- Package `icache_pkg`:
  - state enum;
  - `OFFSET_W`=2;
  - `LINE_BYTES`=4;
  - `BURST_LEN`=2'd3;
  - `ADDR_W`=10, `DATA_W`=8.
- One sub-module, `icache_line_store`: valid/tag/data arrays with a flush-all port, a byte write port (idx, beat, data) and a tag/valid write port. Reads are combinational, indexed by idx.

## Test plan
- Bench memory returns `mem[a]` = `a[7:0]`, with 11 WAIT cycles, then 4 beats.
- Cold miss: read 0x123 → `mem_rreq` once with `mem_raddr`=0x120, `burst_len`=3; `cpu_rdata`=0x23 at cycle 18.
- Hit after fill: read 0x121 → `cpu_rdata`=0x21 at cycle 1; no `mem_rreq`.
- Conflict (`LINES`=16): read 0x040, then 0x140 (same index, different tag) → second read misses and refills from 0x140. A following read of 0x041 misses again.
- Flush: fill 0x200, assert `cpu_flush` with `cpu_req` in the same cycle → `cpu_ready`=0, request not taken. Next read of 0x200 misses.
- Reset mid-REFILL after 2 beats → all outputs 0. Re-read of the same address misses and returns the correct data.
- `ICACHE_PERF_EN`: 3 misses + 5 hits → `miss_cnt`=3, `hit_cnt`=5. Preload `hit_cnt` to 0xFFFF via force → stays at 0xFFFF on the next hit.
